// File: rtl/sentry_rf_read_stage.sv
// Read-issue stage for the 4-wide sentry register RAM: issues addresses, merges
// same-cycle write forwarding into the registered RAM data, and queues results in a FIFO.
module sentry_rf_read_stage #(
    parameter int unsigned NPORTS     = 4,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [NPORTS-1:0]              req_mask,
    input  logic [NPORTS*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NPORTS-1:0]              wr_en,
    input  logic [NPORTS*ADDR_WIDTH-1:0]   wr_addr,
    input  logic [NPORTS*DATA_WIDTH-1:0]   wr_data,
    output logic [NPORTS*ADDR_WIDTH-1:0]   ram_rd_addr,
    input  logic [NPORTS*DATA_WIDTH-1:0]   ram_rd_data,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [NPORTS-1:0]              resp_mask,
    output logic [NPORTS*DATA_WIDTH-1:0]   resp_data
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

    logic                                 accept;
    logic                                 push;
    logic                                 pop;
    logic [NPORTS-1:0]                    fwd_hit;
    logic [NPORTS-1:0][DATA_WIDTH-1:0]    fwd_data;
    logic                                 s1_valid;
    logic [NPORTS-1:0]                    s1_mask;
    logic [NPORTS-1:0]                    s1_hit;
    logic [NPORTS-1:0][DATA_WIDTH-1:0]    s1_data;
    logic [NPORTS*DATA_WIDTH-1:0]         merged;
    logic [NPORTS*DATA_WIDTH-1:0]         mem_data [FIFO_DEPTH];
    logic [NPORTS-1:0]                    mem_mask [FIFO_DEPTH];
    logic [PtrW-1:0]                      rd_ptr;
    logic [PtrW-1:0]                      wr_ptr;
    logic [CntW-1:0]                      count;
    logic [CntW-1:0]                      count_next;
    logic [CntW:0]                        occupancy;

    function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
        return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign ram_rd_addr = req_addr;

    // Reserve a slot for the in-flight S1 entry so the FIFO can never overflow.
    assign occupancy = {1'b0, count} + {{CntW{1'b0}}, s1_valid};
    assign req_ready = rst_n && (occupancy < (CntW + 1)'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;

    // Later write lanes overwrite earlier ones, matching RAM write order.
    always_comb begin
        for (int i = 0; i < NPORTS; i++) begin
            fwd_hit[i]  = 1'b0;
            fwd_data[i] = '0;
            for (int j = 0; j < NPORTS; j++) begin
                if (wr_en[j] && (wr_addr[j*ADDR_WIDTH +: ADDR_WIDTH] ==
                                 req_addr[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
                    fwd_hit[i]  = 1'b1;
                    fwd_data[i] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        merged = '0;
        for (int i = 0; i < NPORTS; i++) begin
            if (s1_mask[i]) begin
                merged[i*DATA_WIDTH +: DATA_WIDTH] =
                    s1_hit[i] ? s1_data[i] : ram_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign push       = s1_valid;
    assign resp_valid = rst_n && (count != '0);
    assign pop        = resp_valid && resp_ready;
    assign resp_mask  = resp_valid ? mem_mask[rd_ptr] : '0;
    assign resp_data  = resp_valid ? mem_data[rd_ptr] : '0;

    always_comb begin
        count_next = count;
        unique case ({push, pop})
            2'b10:   count_next = count + CntW'(1);
            2'b01:   count_next = count - CntW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_mask <= req_mask;
                s1_hit  <= fwd_hit;
                s1_data <= fwd_data;
            end
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            count <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= merged;
            mem_mask[wr_ptr] <= s1_mask;
        end
    end

endmodule

// File: tb/tb_sentry_rf_read_stage.sv
// Scoreboard bench for sentry_rf_read_stage: directed requests push expected responses,
// a negedge monitor pops and compares them against the DUT output.
module tb_sentry_rf_read_stage;

    typedef struct {
        logic [3:0]   mask;
        logic [127:0] data;
        int           cyc;
        bit           exact;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [3:0]   req_mask;
    logic [7:0]   req_addr;
    logic [3:0]   wr_en;
    logic [7:0]   wr_addr;
    logic [127:0] wr_data;
    logic [7:0]   ram_rd_addr;
    logic [127:0] ram_rd_data;
    logic         resp_valid;
    logic         resp_ready;
    logic [3:0]   resp_mask;
    logic [127:0] resp_data;

    logic [31:0]  ram [4];
    exp_t         sb[$];
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;

    sentry_rf_read_stage #(
        .NPORTS(4), .ADDR_WIDTH(2), .DATA_WIDTH(32), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_mask(req_mask), .req_addr(req_addr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_mask(resp_mask), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register RAM: writes in lane order, read data registered (pre-write value).
    always @(posedge clk) begin
        for (int j = 0; j < 4; j++)
            if (wr_en[j]) ram[wr_addr[2*j +: 2]] <= wr_data[32*j +: 32];
        for (int i = 0; i < 4; i++)
            ram_rd_data[32*i +: 32] <= ram[ram_rd_addr[2*i +: 2]];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // RAM contents after the directed forwarding tests (hand-tracked).
    function automatic logic [31:0] word_at(input int a);
        case (a)
            0:       return 32'h55;
            1:       return 32'h77;
            2:       return 32'h22;
            3:       return 32'h34;
            default: return 32'h0;
        endcase
    endfunction

    task automatic issue(input bit v, input logic [3:0] m, input logic [7:0] a,
                         input logic [3:0] we, input logic [7:0] wa, input logic [127:0] wd,
                         input logic [127:0] ed, input bit exact, output bit acc);
        req_valid = v;
        req_mask  = m;
        req_addr  = a;
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        @(negedge clk);
        acc = v && (req_ready === 1'b1);
        if (acc) sb.push_back('{mask: m, data: ed, cyc: cyc, exact: exact});
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wr_en     = 4'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) issue(1'b0, 4'h0, 8'h0, 4'h0, 8'h0, '0, '0, 1'b0, acc);
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        resp_ready = 1'b1;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(name, 128'(sb.size()), 128'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (resp_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got mask %h data %h required none",
                             resp_mask, resp_data);
                end else begin
                    chk("resp_mask", {124'b0, resp_mask}, {124'b0, sb[0].mask});
                    chk("resp_data", resp_data, sb[0].data);
                    if (resp_ready) begin
                        if (sb[0].exact) chk("latency", 128'(cyc - sb[0].cyc), 128'd2);
                        void'(sb.pop_front());
                    end
                end
            end else begin
                chk("idle_mask", {124'b0, resp_mask}, 128'd0);
                chk("idle_data", resp_data, 128'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        int          nacc;
        logic [1:0]  a2;

        // Reset; preload RAM through the write port: {3:D3, 2:B2, 1:A5, 0:C0}.
        rst_n      = 1'b0;
        resp_ready = 1'b0;
        req_valid  = 1'b0;
        req_mask   = 4'h0;
        req_addr   = 8'h0;
        wr_en      = 4'hF;
        wr_addr    = 8'b11_10_01_00;
        wr_data    = {32'hD3, 32'hB2, 32'hA5, 32'hC0};
        @(posedge clk);
        #1;
        wr_en = 4'h0;
        @(negedge clk);
        chk("rst_req_ready", {127'b0, req_ready}, 128'd0);
        chk("rst_resp_valid", {127'b0, resp_valid}, 128'd0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", {127'b0, req_ready}, 128'd1);
        chk("post_rst_resp_valid", {127'b0, resp_valid}, 128'd0);
        @(posedge clk);
        #1;

        // Plain read of addr 1 on all lanes.
        issue(1'b1, 4'hF, 8'h55, 4'h0, 8'h0, '0, {4{32'hA5}}, 1'b1, acc);
        // Same-cycle writes to addr 2 from lanes 0 and 2: lane 2 wins.
        issue(1'b1, 4'hF, 8'b01_11_10_00, 4'b0101, 8'b00_10_00_10,
              {32'h0, 32'h22, 32'h0, 32'h11}, {32'hA5, 32'hD3, 32'h22, 32'hC0}, 1'b1, acc);
        // Write one cycle after issue is invisible; masked lanes read zero.
        issue(1'b1, 4'b0001, 8'h00, 4'h0, 8'h0, '0, {96'b0, 32'hC0}, 1'b1, acc);
        issue(1'b0, 4'h0, 8'h00, 4'b0001, 8'h00, {96'b0, 32'h55}, '0, 1'b0, acc);
        issue(1'b1, 4'b1010, 8'h00, 4'h0, 8'h0, '0, {32'h55, 32'h0, 32'h55, 32'h0}, 1'b1, acc);
        // All four write lanes hit addr 3: lane 3 data wins.
        issue(1'b1, 4'hF, 8'b01_11_01_01, 4'hF, 8'hFF,
              {32'h34, 32'h33, 32'h32, 32'h31}, {32'hA5, 32'h34, 32'hA5, 32'hA5}, 1'b1, acc);
        issue(1'b1, 4'b1001, 8'b01_10_10_01, 4'b0011, 8'b00_00_01_01,
              {32'h0, 32'h0, 32'h77, 32'h66}, {32'h77, 32'h0, 32'h0, 32'h77}, 1'b1, acc);
        drain("drain_fwd", 20);
        idle(2);

        // Back-pressure: exactly four accepted, then stall; drain in order.
        resp_ready = 1'b0;
        nacc       = 0;
        for (int k = 0; k < 6; k++) begin
            a2 = 2'(k);
            issue(1'b1, 4'hF, {4{a2}}, 4'h0, 8'h0, '0, {4{word_at(k % 4)}}, 1'b0, acc);
            if (acc) nacc++;
        end
        chk("fifo_accepts", 128'(nacc), 128'd4);
        @(negedge clk);
        chk("full_req_ready", {127'b0, req_ready}, 128'd0);
        @(posedge clk);
        #1;
        drain("drain_full", 20);
        idle(2);

        // Back-to-back: every response exactly two cycles after its accept.
        for (int k = 0; k < 8; k++) begin
            a2 = 2'(k);
            issue(1'b1, 4'hF, {4{a2}}, 4'h0, 8'h0, '0, {4{word_at(k % 4)}}, 1'b1, acc);
            chk("b2b_accept", {127'b0, acc}, 128'd1);
        end
        drain("drain_b2b", 20);
        idle(2);

        // Reset with two entries queued and S1 busy: everything is discarded.
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++)
            issue(1'b1, 4'hF, 8'hFF, 4'h0, 8'h0, '0, {4{32'h34}}, 1'b0, acc);
        rst_n      = 1'b0;
        resp_ready = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_resp_valid", {127'b0, resp_valid}, 128'd0);
        chk("midrst_req_ready", {127'b0, req_ready}, 128'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_rst_resp_valid", {127'b0, resp_valid}, 128'd0);
        chk("after_rst_req_ready", {127'b0, req_ready}, 128'd1);
        @(posedge clk);
        #1;
        issue(1'b1, 4'b0100, 8'hAA, 4'h0, 8'h0, '0, {32'h0, 32'h22, 32'h0, 32'h0}, 1'b1, acc);
        drain("drain_after_rst", 20);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
